// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// seq_alu : handshaked ALU, single-cycle logic/arith plus iterative shifts/MUL
// Revision: 1.0
// ============================================================================
module seq_alu #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned c_SHW  = $clog2(WIDTH);
  localparam int unsigned c_CNTW = c_SHW + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;
  typedef enum logic [1:0] {K_SLL = 2'd0, K_SRL = 2'd1, K_SRA = 2'd2, K_MUL = 2'd3} kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [c_CNTW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  w_sum, w_diff, w_addnb, w_res;
  logic              w_ovf, w_multi;
  kind_t             w_kind;

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_addnb = a + ~b;

  always_comb begin
    w_res   = '0;
    w_ovf   = 1'b0;
    w_multi = 1'b0;
    w_kind  = K_SLL;
    case (f)
      4'b0000: w_res = a & b;
      4'b0001: w_res = a | b;
      4'b0010: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011: w_res = a & ~b;
      4'b0101: w_res = w_addnb;
      4'b0110: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1000: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1001: begin w_multi = 1'b1; w_kind = K_SLL; end
      4'b1010: begin w_multi = 1'b1; w_kind = K_SRL; end
      4'b1011: begin w_multi = 1'b1; w_kind = K_SRA; end
      4'b1100: begin
        // Without the multiplier this opcode falls through as a single-cycle zero.
        if (MUL_EN) begin
          w_multi = 1'b1;
          w_kind  = K_MUL;
        end
      end
      default: w_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (w_multi) begin
            state_d  = S_EXEC;
            kind_d   = w_kind;
            mcand_d  = a;
            mplier_d = b;
            if (w_kind == K_MUL) begin
              acc_d = '0;
              cnt_d = c_CNTW'(WIDTH);
            end else begin
              acc_d = a;
              cnt_d = {1'b0, b[c_SHW-1:0]};
            end
          end else begin
            y_d    = w_res;
            zero_d = (w_res == '0);
            ovf_d  = w_ovf;
            done_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        // Abort outranks the final writeback so a cancelled op never reports.
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          y_d     = acc_q;
          zero_d  = (acc_q == '0);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - c_CNTW'(1);
          case (kind_q)
            K_SLL:   acc_d = {acc_q[WIDTH-2:0], 1'b0};
            K_SRL:   acc_d = {1'b0, acc_q[WIDTH-1:1]};
            K_SRA:   acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: begin
              if (mplier_q[0]) acc_d = acc_q + mcand_q;
              mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
              mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      kind_q   <= K_SLL;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign y    = y_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_EXEC);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// tb_seq_alu : directed self-checking bench for seq_alu (WIDTH=32, MUL_EN=1).
module tb_seq_alu;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       f = 4'h0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] y;
  logic             zero, ovf, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .f(f),
    .a(a), .b(b), .y(y), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in cycle c and returns during cycle c+1 with start low.
  task automatic issue(input logic [3:0] fi, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi);
    f = fi; a = ai; b = bi; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({y, zero, ovf, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got y=%h z=%b o=%b busy=%b done=%b, expected y=0 z=1 o=0 busy=0 done=0",
               y, zero, ovf, busy, done);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [3:0]       tf [18];
    logic [WIDTH-1:0] ta [18];
    logic [WIDTH-1:0] tb [18];
    logic [WIDTH-1:0] ty [18];
    logic             to [18];
    tf = '{4'h2, 4'h6, 4'h8, 4'h7, 4'hE, 4'h0, 4'h1, 4'h3, 4'h5,
           4'h6, 4'h2, 4'h8, 4'hD, 4'h4, 4'hF, 4'h2, 4'h6, 4'h5};
    ta = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'hF0F01234,
           32'h000000F0, 32'hFFFF0000, 32'h0000000A, 32'h80000000, 32'hFFFFFFFF, 32'h1,
           32'hFFFFFFFF, 32'h1, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    tb = '{32'h1, 32'h5, 32'h1, 32'h1, 32'h9, 32'h0FF0FFFF,
           32'h0F000000, 32'h00FF00FF, 32'h3, 32'h1, 32'h1, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'h1, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    ty = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'h0, 32'h00F01234,
           32'h0F0000F0, 32'hFF000000, 32'h6, 32'h7FFFFFFF, 32'h0, 32'h0,
           32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFE};
    to = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 18; i++) begin
      issue(tf[i], ta[i], tb[i]);
      n_checks++;
      if ({y, zero, ovf, done, busy} !== {ty[i], (ty[i] == '0), to[i], 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL single[%0d] f=%h: got y=%h z=%b o=%b done=%b busy=%b, expected y=%h z=%b o=%b done=1 busy=0",
                 i, tf[i], y, zero, ovf, done, busy, ty[i], (ty[i] == '0), to[i]);
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse: got done=%b expected 0", done);
    end
  endtask

  task automatic test_shift();
    logic [3:0]       sf [6];
    logic [WIDTH-1:0] sa [6];
    logic [WIDTH-1:0] sb [6];
    logic [WIDTH-1:0] sy [6];
    int               sl [6];
    int               lat;
    sf = '{4'hB, 4'h9, 4'hA, 4'h9, 4'hB, 4'hA};
    sa = '{32'h80000000, 32'hA5A50F0F, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'hF0000000};
    sb = '{32'h4, 32'h0, 32'h1F, 32'h23, 32'h1F, 32'h24};
    sy = '{32'hF8000000, 32'hA5A50F0F, 32'h1, 32'h8, 32'h0, 32'h0F000000};
    sl = '{6, 2, 33, 5, 33, 6};
    for (int i = 0; i < 6; i++) begin
      issue(sf[i], sa[i], sb[i]);
      f = 4'h0; a = '1; b = '1;
      lat = 1;
      while (!done && lat < 200) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL shift[%0d] busy at c+%0d: got %b expected 1", i, lat, busy);
        end
        tick();
        lat++;
      end
      n_checks++;
      if ({lat, y, zero, ovf, busy} !== {sl[i], sy[i], (sy[i] == '0), 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL shift[%0d] f=%h: got done@c+%0d y=%h z=%b o=%b busy=%b, expected done@c+%0d y=%h z=%b o=0 busy=0",
                 i, sf[i], lat, y, zero, ovf, busy, sl[i], sy[i], (sy[i] == '0));
      end
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0] ma [4];
    logic [WIDTH-1:0] mb [4];
    logic [WIDTH-1:0] my [4];
    int               lat;
    ma = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00000007};
    mb = '{32'h00010001, 32'h00000003, 32'h00010000, 32'h00000006};
    my = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000000, 32'h0000002A};
    for (int i = 0; i < 4; i++) begin
      issue(4'hC, ma[i], mb[i]);
      lat = 1;
      while (!done && lat < 200) begin
        // A second request while busy must be dropped entirely.
        if (i == 0 && lat == 5) begin
          start = 1'b1; f = 4'h2; a = 32'h1; b = 32'h1;
        end else begin
          start = 1'b0;
        end
        tick();
        lat++;
      end
      start = 1'b0;
      n_checks++;
      if ({lat, y, zero, ovf} !== {34, my[i], (my[i] == '0), 1'b0}) begin
        n_errors++;
        $display("FAIL mul[%0d]: got done@c+%0d y=%h z=%b o=%b, expected done@c+34 y=%h z=%b o=0",
                 i, lat, y, zero, ovf, my[i], (my[i] == '0));
      end
      tick();
      n_checks++;
      if ({done, busy, y} !== {1'b0, 1'b0, my[i]}) begin
        n_errors++;
        $display("FAIL mul_after[%0d]: got done=%b busy=%b y=%h, expected done=0 busy=0 y=%h",
                 i, done, busy, y, my[i]);
      end
    end
  endtask

  task automatic test_abort();
    issue(4'h2, 32'h2, 32'h3);
    issue(4'hC, 32'h3, 32'h3);
    for (int k = 0; k < 9; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, done, y} !== {1'b0, 1'b0, 32'h5}) begin
      n_errors++;
      $display("FAIL abort_mul: got busy=%b done=%b y=%h, expected busy=0 done=0 y=00000005", busy, done, y);
    end
    issue(4'h2, 32'h6, 32'h7);
    n_checks++;
    if ({done, y} !== {1'b1, 32'hD}) begin
      n_errors++;
      $display("FAIL add_after_abort: got done=%b y=%h, expected done=1 y=0000000d", done, y);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_done: got done=%b expected 0", done);
    end
    issue(4'h9, 32'h1, 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, done, y} !== {1'b0, 1'b0, 32'hD}) begin
      n_errors++;
      $display("FAIL abort_vs_writeback: got busy=%b done=%b y=%h, expected busy=0 done=0 y=0000000d", busy, done, y);
    end
    abort = 1'b1;
    issue(4'h2, 32'h1, 32'h2);
    abort = 1'b0;
    n_checks++;
    if ({done, y} !== {1'b1, 32'h3}) begin
      n_errors++;
      $display("FAIL start_beats_abort: got done=%b y=%h, expected done=1 y=00000003", done, y);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(4'h9, 32'h1, 32'h2);
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    n_checks++;
    if ({lat, y, busy} !== {4, 32'h4, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_shift: got done@c+%0d y=%h busy=%b, expected done@c+4 y=00000004 busy=0", lat, y, busy);
    end
    issue(4'h2, 32'h1, 32'h1);
    n_checks++;
    if ({done, y} !== {1'b1, 32'h2}) begin
      n_errors++;
      $display("FAIL b2b_accept_in_done: got done=%b y=%h, expected done=1 y=00000002", done, y);
    end
    f = 4'h2; b = '0; start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a = WIDTH'(i);
      tick();
      n_checks++;
      if ({done, y} !== {1'b1, WIDTH'(i)}) begin
        n_errors++;
        $display("FAIL held_start[%0d]: got done=%b y=%h, expected done=1 y=%h", i, done, y, WIDTH'(i));
      end
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL held_start_end: got done=%b expected 0", done);
    end
  endtask

  task automatic test_reset_midop();
    int n_done;
    issue(4'h2, 32'h1, 32'h1);
    issue(4'hA, 32'hFFFFFFFF, 32'h1F);
    for (int k = 0; k < 4; k++) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({y, zero, ovf, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_midop: got y=%h z=%b o=%b busy=%b done=%b, expected y=0 z=1 o=0 busy=0 done=0",
               y, zero, ovf, busy, done);
    end
    tick(); tick();
    reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) n_done++;
    end
    n_checks++;
    if ({n_done, y} !== {0, 32'h0}) begin
      n_errors++;
      $display("FAIL after_reset_release: got %0d done/busy cycles y=%h, expected 0 and y=0", n_done, y);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_abort();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
